c_arb_split2: RTL

- Clocked 2-way split, the receiving end of the cArbMerge2-style drive/free protocol.
- Takes one upstream drive stream carrying a one-hot destination (`validation_2` style) plus a payload and buffers it in a small tag/data FIFO.
- Forwards each item as a drive pulse to exactly one of two downstream channels, waits for that channel's free, then returns a free to upstream.
- Sits behind a merge tree, at the fan-out point of a clocked micropipeline segment.

---
 rtl/c_arb_pkg.sv | 25 ++
 rtl/c_arb_split2_fifo.sv | 66 ++++++
 rtl/c_arb_split2.sv | 135 +++++++++++++
 3 files changed

// File: rtl/c_arb_pkg.sv
// Shared types for the clocked 2-way split: destination tag encoding,
// FSM states and the select-to-tag mapping.
package c_arb_pkg;

  typedef enum logic [1:0] {
    DROP  = 2'b00,
    DEST0 = 2'b01,
    DEST1 = 2'b10
  } tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // 00 and 11 are not one-hot, so they travel through the FIFO as DROP.
  function automatic tag_t sel_to_tag(input logic [1:0] sel);
    case (sel)
      2'b01:   sel_to_tag = DEST0;
      2'b10:   sel_to_tag = DEST1;
      default: sel_to_tag = DROP;
    endcase
  endfunction

endpackage

// File: rtl/c_arb_split2_fifo.sv
// Tag+data FIFO for the split. When empty, the head view shows the item being
// pushed this cycle so the FSM can act on it without a cycle of delay.
module c_arb_split2_fifo
  import c_arb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [1:0]               pushTag,
  input  logic [DW-1:0]            pushData,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     headValid,
  output logic [1:0]               headTag,
  output logic [DW-1:0]            headData
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [1:0]    tagMem  [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          pushOk, passThru, inc, dec;

  assign full      = (count == FullCnt);
  assign empty     = (count == '0);
  // full is judged on the current count, so a push at DEPTH is refused even if a pop happens too
  assign pushOk    = push && !full;
  assign passThru  = pop && empty && pushOk;
  assign inc       = pushOk && !passThru;
  assign dec       = pop && !empty;

  assign headValid = !empty || pushOk;
  assign headTag   = empty ? pushTag  : tagMem[rdPtr];
  assign headData  = empty ? pushData : dataMem[rdPtr];

  always_ff @(posedge clk) begin
    if (inc) begin
      tagMem[wrPtr]  <= pushTag;
      dataMem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (inc) wrPtr <= wrPtr + 1'b1;
      if (dec) rdPtr <= rdPtr + 1'b1;
      case ({inc, dec})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/c_arb_split2.sv
// Clocked 2-way split: buffers tagged upstream drives and forwards each one to
// a single downstream channel over the drive/free handshake.
module c_arb_split2
  import c_arb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_drive,
  input  logic [1:0]    i_sel_2,
  input  logic [DW-1:0] i_data,
  output logic          o_free,
  output logic          o_full,
  output logic          o_driveNext0,
  output logic          o_driveNext1,
  output logic [DW-1:0] o_data,
  input  logic          i_freeNext0,
  input  logic          i_freeNext1,
  output logic [1:0]    o_validation_2,
  output logic          o_selErr,
  output logic          o_protoErr,
  output logic          o_ovfErr
);

  // state | meaning
  // IDLE  | nothing outstanding downstream; launch or drop the head item
  // WAIT  | head driven to the channel in o_validation_2, awaiting its free

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state, stateNext;
  tag_t          inTag;
  logic          fifoFull, fifoEmpty, headValid, popReq;
  logic [CW-1:0] fifoCount;
  logic [1:0]    headTag;
  logic [DW-1:0] headData;
  logic          driveNext0Nx, driveNext1Nx, freeNx, protoErrNx;
  logic [1:0]    validationNx;
  logic [DW-1:0] dataNx;
  logic          freeMatch, freeOther;

  assign inTag  = sel_to_tag(i_sel_2);
  assign o_full = (fifoCount == CW'(DEPTH));

  // o_validation_2 doubles as the record of which channel is pending
  assign freeMatch = (o_validation_2[0] & i_freeNext0) | (o_validation_2[1] & i_freeNext1);
  assign freeOther = (o_validation_2[0] & i_freeNext1) | (o_validation_2[1] & i_freeNext0);

  c_arb_split2_fifo #(.DW(DW), .DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (i_drive),
    .pushTag  (inTag),
    .pushData (i_data),
    .pop      (popReq),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount),
    .headValid(headValid),
    .headTag  (headTag),
    .headData (headData)
  );

  always_comb begin
    stateNext    = state;
    popReq       = 1'b0;
    driveNext0Nx = 1'b0;
    driveNext1Nx = 1'b0;
    freeNx       = 1'b0;
    validationNx = o_validation_2;
    dataNx       = o_data;
    protoErrNx   = o_protoErr;
    case (state)
      IDLE: begin
        if (i_freeNext0 || i_freeNext1) protoErrNx = 1'b1;
        if (headValid) begin
          case (tag_t'(headTag))
            DEST0: begin
              driveNext0Nx = 1'b1;
              validationNx = 2'b01;
              dataNx       = headData;
              stateNext    = WAIT;
            end
            DEST1: begin
              driveNext1Nx = 1'b1;
              validationNx = 2'b10;
              dataNx       = headData;
              stateNext    = WAIT;
            end
            default: begin
              popReq = 1'b1;
              freeNx = 1'b1;
            end
          endcase
        end
      end
      WAIT: begin
        if (freeMatch && !fifoEmpty) begin
          popReq       = 1'b1;
          freeNx       = 1'b1;
          validationNx = 2'b00;
          stateNext    = IDLE;
        end
        if (freeOther) protoErrNx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      o_driveNext0   <= 1'b0;
      o_driveNext1   <= 1'b0;
      o_free         <= 1'b0;
      o_validation_2 <= 2'b00;
      o_data         <= '0;
      o_selErr       <= 1'b0;
      o_protoErr     <= 1'b0;
      o_ovfErr       <= 1'b0;
    end else begin
      state          <= stateNext;
      o_driveNext0   <= driveNext0Nx;
      o_driveNext1   <= driveNext1Nx;
      o_free         <= freeNx;
      o_validation_2 <= validationNx;
      o_data         <= dataNx;
      o_protoErr     <= protoErrNx;
      if (i_drive && fifoFull)      o_ovfErr <= 1'b1;
      if (i_drive && inTag == DROP) o_selErr <= 1'b1;
    end
  end

endmodule
